// File: rtl/morse_char_decoder.sv
// morse_char_decoder
//   Timing-based Morse receiver. The raw key is synchronised, then timed
//   against a programmable unit period. Each mark is classified as a dot or a
//   dash and buffered. An inter-character gap emits one decoded character
//   (index plus seven-segment glyph). Word gaps and buffer overflow are flagged.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   key_in     in   raw key, 1 = tone/mark (asynchronous, synchronised here)
//   char_valid out  one-cycle strobe, char_id/char_seg updated this cycle
//   char_id    out  0-25 = A-Z, 26-35 = digits 0-9, 63 = unknown/overflow
//   char_seg   out  [6:0] = segments a..g active-low, [7] = 0; 8'hFF = blank
//   word_gap   out  one-cycle strobe on word-gap detection
//   sym_err    out  one-cycle strobe alongside char_valid when buffer overflowed
//   busy       out  high while the receiver is not idle
module morse_char_decoder #(
  parameter int TICK_DIV       = 50000,
  parameter int DOT_MAX_UNITS  = 2,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int MAX_SYMS       = 6,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       char_valid,
  output logic [5:0] char_id,
  output logic [7:0] char_seg,
  output logic       word_gap,
  output logic       sym_err,
  output logic       busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCNT_W = $clog2(MAX_SYMS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  DOT_MAX   = CNT_W'(DOT_MAX_UNITS);
  localparam logic [CNT_W-1:0]  CHAR_GAP  = CNT_W'(CHAR_GAP_UNITS);
  localparam logic [CNT_W-1:0]  WORD_GAP  = CNT_W'(WORD_GAP_UNITS);
  localparam logic [SCNT_W-1:0] SYM_FULL  = SCNT_W'(MAX_SYMS);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  // Unit counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Pattern key is symbol count plus the symbols, first symbol in the MSB of
  // the valid bits; dot = 0, dash = 1. Count 7 is used as a never-match code.
  function automatic logic [5:0] morse_lookup(input logic [2:0] n, input logic [4:0] b);
    logic [5:0] id;
    id = 6'd63;
    case ({n, b})
      {3'd1, 5'b00000}: id = 6'd4;   // E
      {3'd1, 5'b00001}: id = 6'd19;  // T
      {3'd2, 5'b00000}: id = 6'd8;   // I
      {3'd2, 5'b00001}: id = 6'd0;   // A
      {3'd2, 5'b00010}: id = 6'd13;  // N
      {3'd2, 5'b00011}: id = 6'd12;  // M
      {3'd3, 5'b00000}: id = 6'd18;  // S
      {3'd3, 5'b00001}: id = 6'd20;  // U
      {3'd3, 5'b00010}: id = 6'd17;  // R
      {3'd3, 5'b00011}: id = 6'd22;  // W
      {3'd3, 5'b00100}: id = 6'd3;   // D
      {3'd3, 5'b00101}: id = 6'd10;  // K
      {3'd3, 5'b00110}: id = 6'd6;   // G
      {3'd3, 5'b00111}: id = 6'd14;  // O
      {3'd4, 5'b00000}: id = 6'd7;   // H
      {3'd4, 5'b00001}: id = 6'd21;  // V
      {3'd4, 5'b00010}: id = 6'd5;   // F
      {3'd4, 5'b00100}: id = 6'd11;  // L
      {3'd4, 5'b00110}: id = 6'd15;  // P
      {3'd4, 5'b00111}: id = 6'd9;   // J
      {3'd4, 5'b01000}: id = 6'd1;   // B
      {3'd4, 5'b01001}: id = 6'd23;  // X
      {3'd4, 5'b01010}: id = 6'd2;   // C
      {3'd4, 5'b01011}: id = 6'd24;  // Y
      {3'd4, 5'b01100}: id = 6'd25;  // Z
      {3'd4, 5'b01101}: id = 6'd16;  // Q
      {3'd5, 5'b11111}: id = 6'd26;  // 0
      {3'd5, 5'b01111}: id = 6'd27;  // 1
      {3'd5, 5'b00111}: id = 6'd28;  // 2
      {3'd5, 5'b00011}: id = 6'd29;  // 3
      {3'd5, 5'b00001}: id = 6'd30;  // 4
      {3'd5, 5'b00000}: id = 6'd31;  // 5
      {3'd5, 5'b10000}: id = 6'd32;  // 6
      {3'd5, 5'b11000}: id = 6'd33;  // 7
      {3'd5, 5'b11100}: id = 6'd34;  // 8
      {3'd5, 5'b11110}: id = 6'd35;  // 9
      default:          id = 6'd63;
    endcase
    return id;
  endfunction

  // Seven-segment font, bit 6 = a ... bit 0 = g, active-low. Characters with
  // no readable glyph (and unknowns) show only segment g.
  function automatic logic [7:0] glyph(input logic [5:0] id);
    logic [7:0] s;
    case (id)
      6'd0:  s = 8'h08;  6'd1:  s = 8'h60;  6'd2:  s = 8'h31;  6'd3:  s = 8'h42;
      6'd4:  s = 8'h30;  6'd5:  s = 8'h38;  6'd6:  s = 8'h21;  6'd7:  s = 8'h48;
      6'd8:  s = 8'h79;  6'd9:  s = 8'h43;  6'd11: s = 8'h71;  6'd13: s = 8'h6A;
      6'd14: s = 8'h62;  6'd15: s = 8'h18;  6'd16: s = 8'h0C;  6'd17: s = 8'h7A;
      6'd18: s = 8'h24;  6'd19: s = 8'h70;  6'd20: s = 8'h41;  6'd24: s = 8'h44;
      6'd25: s = 8'h12;  6'd26: s = 8'h01;  6'd27: s = 8'h4F;  6'd28: s = 8'h12;
      6'd29: s = 8'h06;  6'd30: s = 8'h4C;  6'd31: s = 8'h24;  6'd32: s = 8'h20;
      6'd33: s = 8'h0F;  6'd34: s = 8'h00;  6'd35: s = 8'h04;
      default: s = 8'h7E;
    endcase
    return s;
  endfunction

  logic                key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    mark_cnt_q, mark_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [MAX_SYMS-1:0] sym_bits_q, sym_bits_d;
  logic [SCNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic                ovf_q, ovf_d;
  logic                char_valid_q, char_valid_d, word_gap_q, word_gap_d;
  logic                sym_err_q, sym_err_d;
  logic [5:0]          char_id_q, char_id_d;
  logic [7:0]          char_seg_q, char_seg_d;

  logic                key_edge, unit_tick;
  logic [CNT_W-1:0]    mark_eff, gap_next;
  logic [2:0]          lk_n;
  logic [5:0]          look_id;

  // Synchroniser and tick generator. The tick phase restarts on every
  // synchronised key edge so mark/space lengths are measured from the edge.
  always_comb begin
    key_s1_d   = key_in;
    key_s2_d   = key_s1_q;
    key_prev_d = key_s2_q;
    key_edge   = key_s2_q ^ key_prev_q;
    unit_tick  = (tick_cnt_q == TICK_LAST);
    if (key_edge || unit_tick) tick_cnt_d = '0;
    else                       tick_cnt_d = tick_cnt_q + TICK_W'(1);
  end

  // Receiver FSM with character emit.
  always_comb begin
    state_d      = state_q;
    mark_cnt_d   = mark_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sym_bits_d   = sym_bits_q;
    sym_cnt_d    = sym_cnt_q;
    ovf_d        = ovf_q;
    char_valid_d = 1'b0;
    word_gap_d   = 1'b0;
    sym_err_d    = 1'b0;
    char_id_d    = char_id_q;
    char_seg_d   = char_seg_q;

    // A tick landing in the same cycle as the key fall still counts toward
    // the mark, so a mark of exactly N units measures N.
    mark_eff = unit_tick ? sat_inc(mark_cnt_q) : mark_cnt_q;
    gap_next = unit_tick ? sat_inc(gap_cnt_q)  : gap_cnt_q;

    // Bits above the 5-symbol window are always zero when count <= 5; any
    // other combination can only be overflow and must not match.
    lk_n    = ((sym_cnt_q > SCNT_W'(5)) || ((sym_bits_q >> 5) != '0)) ? 3'd7 : sym_cnt_q[2:0];
    look_id = morse_lookup(lk_n, sym_bits_q[4:0]);

    case (state_q)
      IDLE: begin
        if (key_s2_q) begin
          state_d    = MARK;
          mark_cnt_d = '0;
        end
      end
      MARK: begin
        mark_cnt_d = mark_eff;
        if (!key_s2_q) begin
          gap_cnt_d = '0;
          if (mark_eff == '0) begin
            // Sub-unit pulse: glitch, no symbol.
            state_d = (sym_cnt_q != '0) ? SPACE : IDLE;
          end else begin
            if (sym_cnt_q == SYM_FULL) begin
              ovf_d = 1'b1;
            end else begin
              sym_bits_d = {sym_bits_q[MAX_SYMS-2:0], (mark_eff > DOT_MAX)};
              sym_cnt_d  = sym_cnt_q + SCNT_W'(1);
            end
            state_d = SPACE;
          end
        end
      end
      SPACE: begin
        gap_cnt_d = gap_next;
        if (unit_tick && (gap_next == CHAR_GAP) && (sym_cnt_q != '0)) begin
          char_valid_d = 1'b1;
          if (ovf_q) begin
            char_id_d  = 6'd63;
            char_seg_d = 8'h7E;
            sym_err_d  = 1'b1;
          end else begin
            char_id_d  = look_id;
            char_seg_d = glyph(look_id);
          end
          sym_bits_d = '0;
          sym_cnt_d  = '0;
          ovf_d      = 1'b0;
        end
        if (unit_tick && (gap_next == WORD_GAP)) begin
          word_gap_d = 1'b1;
          state_d    = IDLE;
        end
        // A rise wins the state but never cancels an emit in the same cycle.
        if (key_s2_q) begin
          state_d    = MARK;
          mark_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1_q     <= 1'b0;
      key_s2_q     <= 1'b0;
      key_prev_q   <= 1'b0;
      tick_cnt_q   <= '0;
      state_q      <= IDLE;
      mark_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      sym_bits_q   <= '0;
      sym_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      char_valid_q <= 1'b0;
      word_gap_q   <= 1'b0;
      sym_err_q    <= 1'b0;
      char_id_q    <= 6'd63;
      char_seg_q   <= 8'hFF;
    end else begin
      key_s1_q     <= key_s1_d;
      key_s2_q     <= key_s2_d;
      key_prev_q   <= key_prev_d;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      mark_cnt_q   <= mark_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sym_bits_q   <= sym_bits_d;
      sym_cnt_q    <= sym_cnt_d;
      ovf_q        <= ovf_d;
      char_valid_q <= char_valid_d;
      word_gap_q   <= word_gap_d;
      sym_err_q    <= sym_err_d;
      char_id_q    <= char_id_d;
      char_seg_q   <= char_seg_d;
    end
  end

  assign char_valid = char_valid_q;
  assign char_id    = char_id_q;
  assign char_seg   = char_seg_q;
  assign word_gap   = word_gap_q;
  assign sym_err    = sym_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_char_decoder.sv
// tb_morse_char_decoder
//   Directed bench for morse_char_decoder with TICK_DIV=4. A behavioural
//   model works on run lengths of the sampled key (in clock cycles) and
//   predicts every output each cycle; literal checks pin the decoded results.
module tb_morse_char_decoder;

  localparam int TD = 4, DOTMAX = 2, CG = 3, WG = 7, MAXS = 6;

  logic       clk = 1'b0, rst = 1'b1, key_in = 1'b0;
  logic       char_valid, word_gap, sym_err, busy;
  logic [5:0] char_id;
  logic [7:0] char_seg;

  always #5 clk = ~clk;

  morse_char_decoder #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .char_valid(char_valid), .char_id(char_id), .char_seg(char_seg),
    .word_gap(word_gap), .sym_err(sym_err), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Morse patterns and glyphs by character index (A-Z then 0-9).
  string morse_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                            "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                            "..-", "...-", ".--", "-..-", "-.--", "--..",
                            "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                            "---..", "----."};
  int seg_tab [36] = '{'h08, 'h60, 'h31, 'h42, 'h30, 'h38, 'h21, 'h48, 'h79, 'h43,
                       'h7E, 'h71, 'h7E, 'h6A, 'h62, 'h18, 'h0C, 'h7A, 'h24, 'h70,
                       'h41, 'h7E, 'h7E, 'h7E, 'h44, 'h12,
                       'h01, 'h4F, 'h12, 'h06, 'h4C, 'h24, 'h20, 'h0F, 'h00, 'h04};

  function automatic int model_id(input string s);
    for (int i = 0; i < 36; i++) if (morse_tab[i] == s) return i;
    return 63;
  endfunction

  // Model: outputs become visible a fixed number of edges after the key
  // sample that causes them (2 sync stages, plus 1 for registered strobes).
  typedef struct { int at; int kind; int id; int seg; bit err; bit val; } ev_t;
  localparam int EV_EMIT = 0, EV_WG = 1, EV_BUSY = 2;
  ev_t pend[$];
  ev_t keep[$];
  int  edge_n = 0;
  bit  chk_en = 1'b0;
  bit  m_cv, m_wg, m_err, m_busy;
  int  m_id, m_seg;
  string syms;
  int  nsyms, run, units, eid, eseg;
  bit  ovf, in_space, prev_k, k;

  task automatic sched(input int at, input int kind, input int id, input int seg, input bit err, input bit val);
    ev_t e;
    e.at = at; e.kind = kind; e.id = id; e.seg = seg; e.err = err; e.val = val;
    pend.push_back(e);
  endtask

  always @(posedge clk) begin
    keep = {};
    m_cv = 1'b0; m_wg = 1'b0; m_err = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].at == edge_n) begin
        case (pend[i].kind)
          EV_EMIT: begin m_cv = 1'b1; m_id = pend[i].id; m_seg = pend[i].seg; m_err = pend[i].err; end
          EV_WG:   begin m_wg = 1'b1; m_busy = 1'b0; end
          default: m_busy = pend[i].val;
        endcase
      end else begin
        keep.push_back(pend[i]);
      end
    end
    pend = keep;
    if (rst) begin
      pend.delete();
      m_cv = 1'b0; m_wg = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      m_id = 63; m_seg = 'hFF;
      syms = ""; nsyms = 0; ovf = 1'b0; in_space = 1'b0; prev_k = 1'b0; run = 0;
      chk_en = 1'b1;
    end else begin
      k = key_in;
      if (k == prev_k) begin
        run++;
      end else begin
        if (!k) begin
          units = run / TD;
          if (units == 0) begin
            if (nsyms == 0) begin
              in_space = 1'b0;
              sched(edge_n + 2, EV_BUSY, 0, 0, 1'b0, 1'b0);
            end
          end else begin
            if (nsyms == MAXS) ovf = 1'b1;
            else begin
              syms = {syms, (units > DOTMAX) ? "-" : "."};
              nsyms++;
            end
            in_space = 1'b1;
          end
        end else begin
          sched(edge_n + 2, EV_BUSY, 0, 0, 1'b0, 1'b1);
        end
        run = 1;
      end
      prev_k = k;
      if (!k && in_space && run == CG * TD && nsyms > 0) begin
        eid  = ovf ? 63 : model_id(syms);
        eseg = (eid == 63) ? 'h7E : seg_tab[eid];
        sched(edge_n + 3, EV_EMIT, eid, eseg, ovf, 1'b0);
        syms = ""; nsyms = 0; ovf = 1'b0;
      end
      if (!k && in_space && run == WG * TD) begin
        sched(edge_n + 3, EV_WG, 0, 0, 1'b0, 1'b0);
        in_space = 1'b0;
      end
    end
    edge_n++;
  end

  // Per-cycle comparison against the model, plus event tallies.
  int n_cv = 0, n_wg = 0, n_err = 0, last_id = -1, last_seg = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("char_valid", char_valid, m_cv);
      check("word_gap",   word_gap,   m_wg);
      check("sym_err",    sym_err,    m_err);
      check("busy",       busy,       m_busy);
      check("char_id",    char_id,    m_id);
      check("char_seg",   char_seg,   m_seg);
      if (char_valid) begin
        n_cv++; last_id = char_id; last_seg = char_seg;
        if (sym_err) n_err++;
      end
      if (word_gap) n_wg++;
    end
  end

  task automatic hold(input logic kv, input int n);
    key_in = kv;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(input int u);  hold(1'b1, u * TD); endtask
  task automatic space(input int u); hold(1'b0, u * TD); endtask

  int cv0, wg0, er0;

  task automatic snap();
    cv0 = n_cv; wg0 = n_wg; er0 = n_err;
  endtask

  initial begin
    rst = 1'b1; key_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_id", char_id, 63);
    check("rst_seg", char_seg, 'hFF);
    check("rst_busy", busy, 0);
    check("rst_cv", char_valid, 0);

    // E then word gap
    snap();
    mark(1); space(3);
    check("e_busy_midgap", busy, 1);
    space(5);
    check("e_cv_count", n_cv - cv0, 1);
    check("e_id", last_id, 4);
    check("e_seg", last_seg, 'h30);
    check("e_model_id", m_id, 4);
    check("e_wg_count", n_wg - wg0, 1);
    check("e_busy_end", busy, 0);

    // T, then a lone 1-clk pulse
    snap();
    mark(3); space(8);
    check("t_cv_count", n_cv - cv0, 1);
    check("t_id", last_id, 19);
    check("t_seg", last_seg, 'h70);
    snap();
    hold(1'b1, 1); space(10);
    check("glitch_cv", n_cv - cv0, 0);
    check("glitch_wg", n_wg - wg0, 0);
    check("glitch_busy", busy, 0);

    // '5' = five dots, '0' = five dashes
    snap();
    for (int i = 0; i < 4; i++) begin mark(1); space(1); end
    mark(1); space(8);
    check("five_id", last_id, 31);
    check("five_seg", last_seg, 'h24);
    check("five_model_seg", m_seg, 'h24);
    for (int i = 0; i < 4; i++) begin mark(3); space(1); end
    mark(3); space(8);
    check("zero_id", last_id, 26);
    check("zero_seg", last_seg, 'h01);
    check("five_zero_cv", n_cv - cv0, 2);

    // 2-unit mark is still a dot: ".-" = A
    mark(2); space(1); mark(3); space(8);
    check("a_id", last_id, 0);
    check("a_seg", last_seg, 'h08);

    // Exactly 3-unit gap followed at once by a new mark: E then T
    snap();
    mark(1); space(3); mark(3); space(8);
    check("coinc_cv", n_cv - cv0, 2);
    check("coinc_id", last_id, 19);
    check("coinc_wg", n_wg - wg0, 1);

    // Seven dots overflow the 6-symbol buffer
    snap();
    for (int i = 0; i < 6; i++) begin mark(1); space(1); end
    mark(1); space(8);
    check("ovf_cv", n_cv - cv0, 1);
    check("ovf_err", n_err - er0, 1);
    check("ovf_id", last_id, 63);
    check("ovf_seg", last_seg, 'h7E);

    // Reset in the middle of a dash
    snap();
    mark(2);
    rst = 1'b1; key_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    space(10);
    check("rstmid_cv", n_cv - cv0, 0);
    check("rstmid_wg", n_wg - wg0, 0);
    check("rstmid_id", char_id, 63);
    check("rstmid_seg", char_seg, 'hFF);
    check("rstmid_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
